// File: rtl/slv_guard_recovery_ctrl.sv
// slv_guard_recovery_ctrl: isolates, drains, resets, holds off and re-opens a guarded AXI subordinate after a timeout
module slv_guard_recovery_ctrl #(
  parameter int CntWidth    = 10,
  parameter int OutstWidth  = 5,
  parameter int RstTimeout  = 256,
  parameter int RecCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   rst_req_i,
  input  logic [CntWidth-1:0]    drain_budget_i,
  input  logic [CntWidth-1:0]    holdoff_i,
  input  logic                   sw_clear_i,
  input  logic                   aw_hs_i,
  input  logic                   ar_hs_i,
  input  logic                   b_hs_i,
  input  logic                   r_last_hs_i,
  output logic                   isolate_o,
  output logic                   slv_rst_req_o,
  input  logic                   rst_stat_i,
  output logic                   guard_clear_o,
  output logic                   irq_o,
  output logic                   fail_o,
  output logic                   busy_o,
  output logic [2:0]             state_o,
  output logic [RecCntWidth-1:0] rec_cnt_o
);
  typedef enum logic [2:0] {IDLE, ISOLATE, DRAIN, RST_ASSERT, RST_RELEASE, HOLDOFF, CLEAR, FAIL} state_e;
  localparam int RtW = $clog2(RstTimeout + 1);
  state_e state;
  logic [CntWidth-1:0] timer;
  logic [RtW-1:0] rst_cnt;
  logic [OutstWidth-1:0] wr_outst, rd_outst, wr_next, rd_next;
  logic rst_to, timer_done, drained;
  always_comb begin
    wr_next = (aw_hs_i && !b_hs_i && !(&wr_outst)) ? wr_outst + 1'b1 :
              (b_hs_i && !aw_hs_i && |wr_outst) ? wr_outst - 1'b1 : wr_outst;
    rd_next = (ar_hs_i && !r_last_hs_i && !(&rd_outst)) ? rd_outst + 1'b1 :
              (r_last_hs_i && !ar_hs_i && |rd_outst) ? rd_outst - 1'b1 : rd_outst;
  end
  assign rst_to     = rst_cnt == RtW'(RstTimeout - 1);
  // timer value 1 means this is the last counted cycle; 0 means a zero budget
  assign timer_done = ~|timer[CntWidth-1:1];
  assign drained    = ~|wr_next && ~|rd_next;
  assign state_o    = state;
  assign busy_o     = state != IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      timer         <= '0;
      rst_cnt       <= '0;
      wr_outst      <= '0;
      rd_outst      <= '0;
      isolate_o     <= 1'b0;
      slv_rst_req_o <= 1'b0;
      guard_clear_o <= 1'b0;
      irq_o         <= 1'b0;
      fail_o        <= 1'b0;
      rec_cnt_o     <= '0;
    end else begin
      wr_outst      <= wr_next;
      rd_outst      <= rd_next;
      guard_clear_o <= 1'b0;
      rst_cnt       <= rst_cnt + 1'b1;
      if (sw_clear_i) irq_o <= 1'b0;
      case (state)
        IDLE: if (enable_i && rst_req_i) begin
          state     <= ISOLATE;
          isolate_o <= 1'b1;
          irq_o     <= 1'b1;
        end
        ISOLATE: begin
          state <= DRAIN;
          timer <= drain_budget_i;
        end
        DRAIN: if (drained || timer_done) begin
          state         <= RST_ASSERT;
          slv_rst_req_o <= 1'b1;
          rst_cnt       <= '0;
        end else timer <= timer - 1'b1;
        RST_ASSERT: if (rst_stat_i) begin
          state         <= RST_RELEASE;
          slv_rst_req_o <= 1'b0;
          rst_cnt       <= '0;
          wr_outst      <= '0;
          rd_outst      <= '0;
        end else if (rst_to) begin
          state         <= FAIL;
          slv_rst_req_o <= 1'b0;
          fail_o        <= 1'b1;
          irq_o         <= 1'b1;
        end
        RST_RELEASE: if (!rst_stat_i) begin
          state <= HOLDOFF;
          timer <= holdoff_i;
        end else if (rst_to) begin
          state  <= FAIL;
          fail_o <= 1'b1;
          irq_o  <= 1'b1;
        end
        HOLDOFF: if (timer_done) begin
          state         <= CLEAR;
          guard_clear_o <= 1'b1;
          if (!(&rec_cnt_o)) rec_cnt_o <= rec_cnt_o + 1'b1;
        end else timer <= timer - 1'b1;
        CLEAR: begin
          state     <= IDLE;
          isolate_o <= 1'b0;
        end
        FAIL: if (sw_clear_i) begin
          state     <= IDLE;
          fail_o    <= 1'b0;
          isolate_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
